// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the NAND SR latch driver.
// Holds the controller state encoding and the feedback synchronizer depth.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        VERIFY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int max3(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sr_latch_driver_sync.sv
// Two-flop synchronizer bringing the latch Q into the clk domain.
// Cleared by rst so the controller never sees a stale Q after reset.
module sync_2ff
    import sr_latch_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // shift the asynchronous input through the synchronizer chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Drives active-low s_n/r_n of a NAND SR latch from a valid/ready command.
// Optional SR_DRIVER_SKIP_EN: skip the pulse when Q already equals the target.
module sr_latch_driver
    import sr_latch_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_set,
    output logic s_n,
    output logic r_n,
    input  logic q_fb,
    output logic done,
    output logic err
);

    localparam int CNT_MAX = max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_target;
    logic             w_target_nxt;
    logic             r_s_n;
    logic             r_r_n;
    logic             w_s_n_nxt;
    logic             w_r_n_nxt;
    logic             r_done;
    logic             r_err;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_hs;
    logic             w_q_sync;

    sync_2ff u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (q_fb),
        .o_q   (w_q_sync)
    );

    assign cmd_ready = (r_state == IDLE);
    assign w_hs      = cmd_valid & cmd_ready;

    // next state, counter, target and output strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_target_nxt = r_target;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_hs) begin
                    w_target_nxt = cmd_set;
`ifdef SR_DRIVER_SKIP_EN
                    if (cmd_set == w_q_sync) begin
                        w_state_nxt = GAP;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = DRIVE;
                    end
`else
                    w_state_nxt = DRIVE;
`endif
                end
            end
            DRIVE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = VERIFY;
                    w_cnt_nxt   = '0;
                end
            end
            VERIFY: begin
                if (w_q_sync == r_target) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = GAP;
                w_cnt_nxt   = '0;
            end
        endcase
        // strobes follow the next state so only one can ever be low
        w_s_n_nxt = !((w_state_nxt == DRIVE) && w_target_nxt);
        w_r_n_nxt = !((w_state_nxt == DRIVE) && !w_target_nxt);
    end

    // state, counter and registered latch strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= GAP;
            r_cnt    <= '0;
            r_target <= 1'b0;
            r_s_n    <= 1'b1;
            r_r_n    <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_s_n    <= w_s_n_nxt;
            r_r_n    <= w_r_n_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign s_n  = r_s_n;
    assign r_n  = r_r_n;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioral NAND SR latch.
// Honors SR_DRIVER_SKIP_EN when computing the skip-case expectations.
module tb_sr_latch_driver;

    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_set = 1'b0;
    logic cmd_ready;
    logic s_n;
    logic r_n;
    logic q_fb;
    logic done;
    logic err;

    logic q_lat = 1'b0;
    logic stuck = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   overlap = 0;

    sr_latch_driver #(
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_set   (cmd_set),
        .s_n       (s_n),
        .r_n       (r_n),
        .q_fb      (q_fb),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // NAND latch: low s_n sets, low r_n resets, otherwise hold
    always @(s_n or r_n) begin
        if (!s_n && r_n) q_lat = 1'b1;
        else if (s_n && !r_n) q_lat = 1'b0;
    end

    assign q_fb = stuck ? 1'b0 : q_lat;

    always @(negedge clk) begin
        if (!s_n && !r_n) overlap++;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", cmd_ready, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_s_n", s_n, 1'b1);
        chk("rst_r_n", r_n, 1'b1);
        chk("rst_rdy", cmd_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_rdy", cmd_ready, 1'b0);
            chk("rst_hold_s_n", s_n, 1'b1);
            chk("rst_hold_done", done, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_rdy_c2", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_rdy_c3", cmd_ready, 1'b1);
    endtask

    // one command, checked cycle by cycle through cycle rdy_c
    task automatic do_cmd(
        input logic set,
        input int   slen,
        input int   done_c,
        input int   err_c,
        input int   rdy_c
    );
        logic lo;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_set   = set;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_set   = ~set;
        for (int c = 1; c <= rdy_c; c++) begin
            lo = (c <= slen);
            chk("cmd_s_n", s_n, !(lo && set));
            chk("cmd_r_n", r_n, !(lo && !set));
            chk("cmd_done", done, c == done_c);
            chk("cmd_err", err, c == err_c);
            chk("cmd_rdy", cmd_ready, c >= rdy_c);
            if (c < rdy_c) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #1;
        do_reset();

        do_cmd(1'b1, P, P + 2, 0, P + G + 2);
        chk("latch_set", q_lat, 1'b1);
        do_cmd(1'b0, P, P + 2, 0, P + G + 2);
        chk("latch_clr", q_lat, 1'b0);

        // back-to-back set then reset with cmd_valid held
        wait_ready();
        cmd_valid = 1'b1;
        cmd_set   = 1'b1;
        @(posedge clk);
        #1;
        cmd_set = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk("b2b_s_n", s_n, !(c <= 4));
            chk("b2b_r_n", r_n, !(c >= 9 && c <= 12));
            chk("b2b_done", done, c == 6 || c == 14);
            chk("b2b_err", err, 1'b0);
            chk("b2b_rdy", cmd_ready, c == 8 || c == 16);
            if (c == 9) cmd_valid = 1'b0;
            if (c < 16) begin
                @(posedge clk);
                #1;
            end
        end
        chk("b2b_latch", q_lat, 1'b0);

        // feedback stuck low: timeout path
        stuck = 1'b1;
        do_cmd(1'b1, P, 0, P + T + 2, P + T + G + 2);
        stuck = 1'b0;
        repeat (4) @(posedge clk);

        // set while Q is already 1
`ifdef SR_DRIVER_SKIP_EN
        do_cmd(1'b1, 0, 1, 0, G + 1);
`else
        do_cmd(1'b1, P, P + 2, 0, P + G + 2);
`endif

        // reset in the second DRIVE cycle of a reset command
        wait_ready();
        cmd_valid = 1'b1;
        cmd_set   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mid_r_n_c1", r_n, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_r_n_c2", r_n, 1'b0);
        #2;
        do_reset();

        do_cmd(1'b1, P, P + 2, 0, P + G + 2);

        chk("no_overlap", overlap == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
